mem_access_ctrl: RTL
====================

# mem_access_ctrl

- Sits in the MEM stage, between the EX/MEM pipeline register and the `DataMemory` block.
- Turns pipeline load/store requests (byte, halfword, word; signed or unsigned loads) into word-wide memory transactions.
- Does read-modify-write for sub-word stores and extracts and extends sub-word load data.
- Holds `stall` high until the memory's status handshake completes, and flags misaligned accesses and memory timeouts.

## Interface
- `MAX_WAIT`, 255: maximum cycles spent in one memory wait state before a timeout error (1..255).
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  EX/MEM holds a memory op; held stable with all `req_*` while `stall`=1.
- `req_write`  in  1  1=store, 0=load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend loads (ignored for stores and word loads).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `stall`  out  1  freeze pipeline (combinational).
- `resp_valid`  out  1  one-cycle pulse: op finished (load data valid or store committed).
- `resp_rdata`  out  32  extracted/extended load data; 0 for stores and errors.
- `addr_error`  out  1  with `resp_valid`: misaligned or illegal size.
- `mem_error`  out  1  with `resp_valid`: timeout.
- `mem_valid`  out  1  memory request active.
- `mem_addr`  out  32  `{req_addr[31:2],2'b00}`.
- `mem_write_enabled`  out  1  memory write strobe.
- `mem_w_data`  out  32  full word to write.
- `mem_r_data`  in  32  memory read word, valid when `mem_status`=10.
- `mem_status`  in  2  00 idle, 01 busy, 10 done; the memory cycles 00→01…→10→00 autonomously.

## Operation
- States:
  - IDLE: no memory op in flight.
  - RD: waiting for a word read.
  - WR: waiting for a word write.
  - DONE: response cycle.
- Reset (async) → IDLE; all outputs and internal registers zero.
- IDLE with `req_valid`=1:
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 11 → DONE, `addr_error`=1, no memory access.
  - Load or byte/half store → RD.
  - Word store → WR.
- `mem_valid`, `mem_addr`, `mem_write_enabled`, `mem_w_data` are registered:
  - driven from the cycle a wait state is entered;
  - held constant through completion;
  - zero in IDLE and DONE.
  - RD drives `mem_write_enabled`=0; WR drives 1.
- Arming: entering RD or WR clears `armed`. `mem_status`=00 seen in the wait state sets `armed`. Only `mem_status`=10 while `armed`=1 counts as completion; an unarmed 10 is ignored.
- RD completion:
  - Capture `mem_r_data`.
  - Load → DONE.
  - Sub-word store → merge the new lane into the captured word, drive it on `mem_w_data`, → WR.
- WR completion → DONE.
- Lanes are little-endian:
  - byte k = word[8k+7:8k] with k=addr[1:0];
  - half h = word[16h+15:16h] with h=addr[1].
  - Merge replaces only the addressed lane with `req_wdata[7:0]` or `req_wdata[15:0]`.
- Load extension: signed → replicate the lane MSB; unsigned → zero-fill.
- Wait counter:
  - reset on entry to RD/WR; increments each wait cycle;
  - reaching `MAX_WAIT` → DONE with `mem_error`=1, `resp_rdata`=0, no WR phase.
- DONE: `resp_valid`=1 for exactly one cycle → IDLE unconditionally.

## Timing
- `stall` = `req_valid` & (state≠DONE). Pipeline advances at the edge ending DONE; the next request is seen in IDLE.
- Memory latency L (`latency_cycles`) gives a memory period P=L+2. L=1 → P=3.
- Stall cycles at L=1:
  - Word load or word store: 4 best case, 6 worst (alignment wait up to P−1).
  - Sub-word store: 7 best case, 9 worst. WR arms in its first cycle because the memory returns to 00 right after 10.
  - Misaligned or illegal access: 1 stall cycle (IDLE), then DONE.
- Back-to-back requests: one IDLE cycle between consecutive DONE states.
- `reset` mid-transaction:
  - Immediate return to IDLE; no `resp_valid`; `mem_valid` drops asynchronously.
  - The memory block is reset on the same signal.

## Test plan
- lw, addr 0x100, memory word 0x8899AABB, L=1 → `resp_valid` pulse, `resp_rdata`=0x8899AABB, stall 4–6 cycles, `mem_addr`=0x100, `mem_write_enabled`=0 throughout.
- lb/lbu/lh/lhu on word 0x8899AABB:
  - lb addr 0x103 → 0xFFFFFF88
  - lbu addr 0x103 → 0x00000088
  - lh addr 0x100 → 0xFFFFAABB
  - lhu addr 0x102 → 0x00008899
- sb 0x5A to addr 0x101 over word 0x11223344 → one read, then one write of 0x11225A44; sh 0xBEEF to addr 0x102 → write 0xBEEF3344.
- lw addr 0x102, lh addr 0x101, and size 11 → `addr_error`+`resp_valid` one cycle after request; `mem_valid` never asserts; stall exactly 1 cycle.
- Force `mem_status` stuck at 01 with `MAX_WAIT`=8 → DONE after 8 wait cycles with `mem_error`=1, `resp_rdata`=0. Also inject a 10 before any 00 → ignored, no early completion.
- Assert `reset` during WR of a sub-word store → all outputs 0 in the same cycle; no `resp_valid`; the next request after release completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Word-wide memory bus between mem_access_ctrl (master) and the DataMemory block (slave).
interface mem_access_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_write_enabled;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_status;

  modport master (
    output mem_valid, mem_addr, mem_write_enabled, mem_w_data,
    input  mem_r_data, mem_status
  );

  modport slave (
    input  mem_valid, mem_addr, mem_write_enabled, mem_w_data,
    output mem_r_data, mem_status
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns byte/half/word loads and stores into word transactions,
// with read-modify-write for sub-word stores, load extension, alignment and timeout errors.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               stall,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               addr_error,
  output logic               mem_error,
  mem_access_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  state_t      next_state;
  logic        armed;
  logic [7:0]  wait_cnt;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q;
  logic        mem_we_q;
  logic [31:0] mem_w_data_q;
  logic [31:0] resp_rdata_q;
  logic        addr_error_q;
  logic        mem_error_q;

  logic        bad_access;
  logic        word_store;
  logic        waiting;
  logic        complete;
  logic        timeout;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [4:0]  lane_shift;

  // Request decode, handshake qualification and lane extract/merge.
  always_comb begin
    bad_access = 1'b0;
    case (req_size)
      2'b00:   bad_access = 1'b0;
      2'b01:   bad_access = req_addr[0];
      2'b10:   bad_access = |req_addr[1:0];
      default: bad_access = 1'b1;
    endcase
    word_store = req_write && (req_size == 2'b10);
    waiting    = (state == RD) || (state == WR);
    // A done status only counts once the memory has been seen idle in this wait state.
    complete   = waiting && armed && (bus.mem_status == 2'b10);
    timeout    = waiting && !complete && (wait_cnt == WAIT_LAST);

    rd_byte = bus.mem_r_data[7:0];
    case (req_addr[1:0])
      2'd0: rd_byte = bus.mem_r_data[7:0];
      2'd1: rd_byte = bus.mem_r_data[15:8];
      2'd2: rd_byte = bus.mem_r_data[23:16];
      2'd3: rd_byte = bus.mem_r_data[31:24];
      default: rd_byte = bus.mem_r_data[7:0];
    endcase
    rd_half = req_addr[1] ? bus.mem_r_data[31:16] : bus.mem_r_data[15:0];

    load_data   = bus.mem_r_data;
    merged_word = bus.mem_r_data;
    lane_shift  = 5'd0;
    case (req_size)
      2'b00: begin
        load_data   = {{24{req_signed & rd_byte[7]}}, rd_byte};
        lane_shift  = {req_addr[1:0], 3'b000};
        merged_word = (bus.mem_r_data & ~(32'h0000_00FF << lane_shift))
                    | ({24'h0, req_wdata[7:0]} << lane_shift);
      end
      2'b01: begin
        load_data   = {{16{req_signed & rd_half[15]}}, rd_half};
        lane_shift  = {req_addr[1], 4'b0000};
        merged_word = (bus.mem_r_data & ~(32'h0000_FFFF << lane_shift))
                    | ({16'h0, req_wdata[15:0]} << lane_shift);
      end
      default: begin
        load_data   = bus.mem_r_data;
        merged_word = bus.mem_r_data;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = bad_access ? DONE : (word_store ? WR : RD);
      RD:   if (complete) next_state = req_write ? WR : DONE;
            else if (timeout) next_state = DONE;
      WR:   if (complete || timeout) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (state == DONE);
    stall      = req_valid && (state != DONE);
  end

  // Memory-side registers are loaded on entry to a wait state and cleared when leaving it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      wait_cnt     <= 8'd0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_w_data_q <= 32'h0;
      resp_rdata_q <= 32'h0;
      addr_error_q <= 1'b0;
      mem_error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (bad_access) begin
              addr_error_q <= 1'b1;
            end else begin
              mem_valid_q  <= 1'b1;
              mem_addr_q   <= {req_addr[31:2], 2'b00};
              mem_we_q     <= word_store;
              mem_w_data_q <= word_store ? req_wdata : 32'h0;
              armed        <= 1'b0;
              wait_cnt     <= 8'd0;
            end
          end
        end
        RD, WR: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.mem_status == 2'b00) armed <= 1'b1;
          if (complete && (state == RD) && req_write) begin
            mem_we_q     <= 1'b1;
            mem_w_data_q <= merged_word;
            armed        <= 1'b0;
            wait_cnt     <= 8'd0;
          end else if (complete || timeout) begin
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_w_data_q <= 32'h0;
            armed        <= 1'b0;
            wait_cnt     <= 8'd0;
            if (timeout)            mem_error_q  <= 1'b1;
            else if (state == RD)   resp_rdata_q <= load_data;
          end
        end
        DONE: begin
          resp_rdata_q <= 32'h0;
          addr_error_q <= 1'b0;
          mem_error_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata            = resp_rdata_q;
  assign addr_error            = addr_error_q;
  assign mem_error             = mem_error_q;
  assign bus.mem_valid         = mem_valid_q;
  assign bus.mem_addr          = mem_addr_q;
  assign bus.mem_write_enabled = mem_we_q;
  assign bus.mem_w_data        = mem_w_data_q;

endmodule
